imgproc_msg_reader: RTL and testbench

IMGPROC_MSG_READER -- requirements
Module: imgproc_msg_reader

---
 rtl/imgproc_msg_reader.sv | 189 ++++++++++++++++++
 tb/tb_imgproc_msg_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that polls the image-processor FIFO and decodes 3-word bounding-box messages.
// Optional macro IMGPROC_MSG_READER_FLUSH_ON_START_EN: clear the slave FIFO once after reset.
module imgproc_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter logic [31:0] MSG_ID        = 32'h00524242
) (
  input  logic        clk,
  input  logic        reset,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        enable,
  output logic [10:0] bb_x_min,
  output logic [10:0] bb_y_min,
  output logic [10:0] bb_x_max,
  output logic [10:0] bb_y_max,
  output logic        bb_valid,
  output logic [15:0] msg_count,
  output logic [7:0]  err_count
);

  typedef enum logic [3:0] {
    StIdle, StPoll, StPollWait, StRdId, StIdWait, StRdTl, StTlWait,
    StRdBr, StBrWait, StPublish,
`ifdef IMGPROC_MSG_READER_FLUSH_ON_START_EN
    StBackoff, StFlush
`else
    StBackoff
`endif
  } state_e;

`ifdef IMGPROC_MSG_READER_FLUSH_ON_START_EN
  localparam state_e ResetSt = StFlush;
`else
  localparam state_e ResetSt = StIdle;
`endif

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [10:0] tl_x_q, tl_x_d, tl_y_q, tl_y_d;
  logic [10:0] x_min_q, x_min_d, y_min_q, y_min_d, x_max_q, x_max_d, y_max_q, y_max_d;
  logic        valid_q, valid_d;
  logic [15:0] msg_q, msg_d;
  logic [7:0]  err_q, err_d;
  logic        rd_q, rd_d, cs_q, cs_d, wr_d;
  logic [3:0]  addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tl_x_d  = tl_x_q;
    tl_y_d  = tl_y_q;
    x_min_d = x_min_q;
    y_min_d = y_min_q;
    x_max_d = x_max_q;
    y_max_d = y_max_q;
    valid_d = 1'b0;
    msg_d   = msg_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    unique case (state_q)
      StIdle:     if (enable) state_d = StPoll;
      StPoll:     state_d = StPollWait;
      StPollWait: begin
        if (m_readdata[15:8] >= 8'd3) begin
          state_d = StRdId;
        end else begin
          state_d = StBackoff;
          cnt_d   = 32'(POLL_INTERVAL);
        end
      end
      StRdId:     state_d = StIdWait;
      StIdWait: begin
        if (m_readdata == MSG_ID) begin
          state_d = StRdTl;
        end else begin
          // Dropping one word per attempt walks the FIFO back into alignment.
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = StIdle;
        end
      end
      StRdTl:     state_d = StTlWait;
      StTlWait: begin
        tl_x_d  = m_readdata[26:16];
        tl_y_d  = m_readdata[10:0];
        state_d = StRdBr;
      end
      StRdBr:     state_d = StBrWait;
      StBrWait: begin
        x_min_d = tl_x_q;
        y_min_d = tl_y_q;
        x_max_d = m_readdata[26:16];
        y_max_d = m_readdata[10:0];
        valid_d = 1'b1;
        msg_d   = msg_q + 16'd1;
        state_d = StPublish;
      end
      StPublish:  state_d = StIdle;
      StBackoff: begin
        // Exit on 1 so the counter lands on 0 exactly POLL_INTERVAL cycles after entry.
        if (cnt_q <= 32'd1) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`ifdef IMGPROC_MSG_READER_FLUSH_ON_START_EN
      StFlush: begin
        wr_d    = 1'b1;
        state_d = StIdle;
      end
`endif
      default:    state_d = StIdle;
    endcase
    rd_d   = (state_d == StPoll) || (state_d == StRdId) ||
             (state_d == StRdTl) || (state_d == StRdBr);
    addr_d = (rd_d && state_d != StPoll) ? 4'd1 : 4'd0;
    cs_d   = rd_d | wr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ResetSt;
      cnt_q   <= '0;
      tl_x_q  <= '0;
      tl_y_q  <= '0;
      x_min_q <= '0;
      y_min_q <= '0;
      x_max_q <= '0;
      y_max_q <= '0;
      valid_q <= 1'b0;
      msg_q   <= '0;
      err_q   <= '0;
      rd_q    <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tl_x_q  <= tl_x_d;
      tl_y_q  <= tl_y_d;
      x_min_q <= x_min_d;
      y_min_q <= y_min_d;
      x_max_q <= x_max_d;
      y_max_q <= y_max_d;
      valid_q <= valid_d;
      msg_q   <= msg_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
    end
  end

`ifdef IMGPROC_MSG_READER_FLUSH_ON_START_EN
  logic        wr_q;
  logic [31:0] wdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      wdata_q <= wr_d ? 32'h00000010 : 32'h0;
    end
  end
  assign m_write     = wr_q;
  assign m_writedata = wdata_q;
`else
  assign m_write     = 1'b0;
  assign m_writedata = '0;
`endif

  assign m_chipselect = cs_q;
  assign m_read       = rd_q;
  assign m_address    = addr_q;
  assign bb_x_min     = x_min_q;
  assign bb_y_min     = y_min_q;
  assign bb_x_max     = x_max_q;
  assign bb_y_max     = y_max_q;
  assign bb_valid     = valid_q;
  assign msg_count    = msg_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Directed bench for imgproc_msg_reader with a latency-1 FIFO slave model.
module tb_imgproc_msg_reader;
  localparam int unsigned PI = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        m_chipselect, m_read, m_write;
  logic [3:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
  logic [10:0] bb_x_min, bb_y_min, bb_x_max, bb_y_max;
  logic        bb_valid;
  logic [15:0] msg_count;
  logic [7:0]  err_count;

  imgproc_msg_reader #(.POLL_INTERVAL(PI), .MSG_ID(32'h00524242)) dut (
    .clk(clk), .reset(reset), .m_chipselect(m_chipselect), .m_read(m_read),
    .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .enable(enable), .bb_x_min(bb_x_min), .bb_y_min(bb_y_min),
    .bb_x_max(bb_x_max), .bb_y_max(bb_y_max), .bb_valid(bb_valid), .msg_count(msg_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: status word carries usedw in [15:8]; address 1 pops the FIFO.
  logic [31:0] fifo[$];
  always @(posedge clk) begin
    if (m_chipselect && m_read) begin
      if (m_address == 4'd0) m_readdata <= {16'h0, 8'(fifo.size()), 8'h0};
      else if (fifo.size() > 0) m_readdata <= fifo.pop_front();
      else m_readdata <= 32'h0;
    end
  end

  // Bus monitor, sampled on the falling edge.
  logic     mon_clr = 1'b0;
  int       cyc = 0, rd1 = 0, pulses = 0, viol = 0, writes = 0, first_kind = 0;
  int       polls[$];
  logic     prev_rd = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_addr = '0;
  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      rd1 = 0; pulses = 0; viol = 0; writes = 0; first_kind = 0;
      polls.delete();
    end else begin
      if (m_read) begin
        if (prev_rd) viol++;
        if (first_kind == 0) first_kind = 2;
        if (m_address == 4'd0) polls.push_back(cyc);
        else rd1++;
      end
      if (m_write) begin
        writes++;
        wr_data = m_writedata;
        wr_addr = m_address;
        if (first_kind == 0) first_kind = 1;
      end
      if (bb_valid) pulses++;
    end
    prev_rd = m_read;
  end

  task automatic clear_mon();
    @(negedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    fifo.delete();
    clear_mon();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int k = 0;
    while (pulses < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(pulses >= n), 32'd1);
  endtask

  task automatic push_msg(input logic [31:0] tl, input logic [31:0] br);
    fifo.push_back(32'h00524242);
    fifo.push_back(tl);
    fifo.push_back(br);
  endtask

  task automatic check_bb(input string tag, input int x0, input int y0, input int x1,
                          input int y1);
    check({tag, "_xmin"}, 32'(bb_x_min), 32'(x0));
    check({tag, "_ymin"}, 32'(bb_y_min), 32'(y0));
    check({tag, "_xmax"}, 32'(bb_x_max), 32'(x1));
    check({tag, "_ymax"}, 32'(bb_y_max), 32'(y1));
  endtask

  initial begin
    int k;
    // Reset values
    clear_mon();
    repeat (2) @(negedge clk);
    check("rst_bb", {bb_x_min, bb_y_min[9:0], bb_x_max}, 32'h0);
    check("rst_ymax", 32'(bb_y_max), 32'h0);
    check("rst_valid", 32'(bb_valid), 32'h0);
    check("rst_msg", 32'(msg_count), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);
    check("rst_strobes", {29'h0, m_chipselect, m_read, m_write}, 32'h0);
    check("rst_addr", 32'(m_address), 32'h0);
    check("rst_wdata", m_writedata, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
`ifdef IMGPROC_MSG_READER_FLUSH_ON_START_EN
    check("flush_first_is_write", 32'(first_kind), 32'd1);
    check("flush_addr", 32'(wr_addr), 32'd0);
    check("flush_data", wr_data, 32'h10);
    check("flush_count", 32'(writes), 32'd1);
`endif

    // Single message decode
    do_reset();
    push_msg(32'h000A0014, 32'h01E00190);
    enable = 1'b1;
    wait_pulses("basic", 1);
    check_bb("basic", 10, 20, 480, 400);
    repeat (5) @(negedge clk);
    check("basic_pulses", 32'(pulses), 32'd1);
    check("basic_msg", 32'(msg_count), 32'd1);

    // usedw=2: back off, no message reads
    do_reset();
    fifo.push_back(32'h00524242);
    fifo.push_back(32'h000A0014);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("bo_polls", 32'(polls.size() >= 2), 32'd1);
    if (polls.size() >= 2) check("bo_interval", 32'(polls[1] - polls[0]), 32'(PI + 3));
    check("bo_no_rd1", 32'(rd1), 32'd0);

    // Bad ID then a valid message
    do_reset();
    fifo.push_back(32'hDEADBEEF);
    push_msg(32'h00050006, 32'h00640032);
    enable = 1'b1;
    wait_pulses("badid", 1);
    check_bb("badid", 5, 6, 100, 50);
    check("badid_err", 32'(err_count), 32'd1);
    check("badid_msg", 32'(msg_count), 32'd1);

    // Reset after the TL read
    do_reset();
    push_msg(32'h00070008, 32'h00090003);
    enable = 1'b1;
    k = 0;
    while (rd1 < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("midrst_reach_tl", 32'(rd1), 32'd2);
    do_reset();
    repeat (10) @(negedge clk);
    check_bb("midrst", 0, 0, 0, 0);
    check("midrst_pulses", 32'(pulses), 32'd0);
    push_msg(32'h00110022, 32'h00330044);
    enable = 1'b1;
    wait_pulses("midrst_after", 1);
    check_bb("midrst_after", 17, 34, 51, 68);
    check("midrst_msg", 32'(msg_count), 32'd1);

    // Back-to-back messages; ignored bits set in the second one
    do_reset();
    push_msg(32'h00010002, 32'h00030004);
    push_msg(32'hF80107FF, 32'h07FFF800);
    enable = 1'b1;
    wait_pulses("b2b", 2);
    check_bb("b2b", 1, 2047, 2047, 0);
    check("b2b_rd1", 32'(rd1), 32'd6);
    check("b2b_read_gap", 32'(viol), 32'd0);
    check("b2b_msg", 32'(msg_count), 32'd2);
`ifndef IMGPROC_MSG_READER_FLUSH_ON_START_EN
    check("no_writes", 32'(writes), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
